decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor to the single-register decode stage.
- Sits between fetch and execute. Buffers fetched instructions in a DEPTH-entry FIFO with a valid/ready handshake on both sides, plus a flush port.
- Fully decodes the head entry: register fields, immediate in four extension modes, and jump target.
- Removes the old stage's one-cycle data/jump-flag skew and its lack of backpressure.

Parameters:
- DEPTH, 2, number of buffered instructions; integer >= 1, need not be a power of two.
- PC_W, 32, width of pc and of every 32-bit data output.
- BR_SHIFT, 2, left shift applied to the branch immediate.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; state cleared on a rising clk edge while reset==0.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept this cycle.
- in_pc  input  PC_W  pc of the presented instruction.
- in_instr  input  32  instruction word.
- in_jump  input  1  fetch-side jump marker, carried with the entry.
- flush  input  1  discard all entries, including any concurrent push.
- out_valid  output  1  head entry valid.
- out_ready  input  1  execute consumes the head.
- out_pc  output  PC_W  head pc.
- out_instr  output  32  head instruction.
- out_jump  output  1  head jump marker.
- out_op  output  6  instr[31:26].
- out_func  output  6  instr[5:0].
- out_rs  output  5  instr[25:21].
- out_rt  output  5  instr[20:16].
- out_rd  output  5  instr[15:11].
- out_shamt  output  5  instr[10:6].
- out_imm  output  PC_W  extended immediate (see Behaviour).
- out_jtarget  output  PC_W  {pc[PC_W-1:PC_W-4], instr[25:0], 2'b00}.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State: circular storage of {pc, instr, jump} ×DEPTH, head/tail pointers wrapping at DEPTH-1 → 0 (modulo DEPTH, not power-of-two masking), occupancy counter.
- Reset (reset==0 at edge): pointers=0, count=0. The storage array need not be cleared.
- in_ready = (count != DEPTH). It is purely registered-state based and does not depend on out_ready (no full-bypass).
- out_valid = (count != 0).
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: in_ready=0, so no push, even if pop occurs that cycle. in_ready rises the cycle after the pop.
- Empty: pop impossible. Push when empty is visible at the outputs the next cycle; minimum latency is 1 cycle. There is no in→out combinational path.
- flush: highest priority below reset. At the edge, count=0 and pointers=0; push and pop that cycle are ignored. in_ready/out_valid combinational values are unaffected during the flush cycle itself.
- Reset mid-operation: identical to flush, and overrides it.
- Outputs are combinationally decoded from the head entry.
- When out_valid==0, every data output (out_pc … out_jtarget, out_jump) is forced to 0. All outputs are therefore 0 after reset.
- out_imm, by out_op:
  - 0x04 BEQ / 0x05 BNE: sign-extend(imm16) << BR_SHIFT.
  - 0x0C ANDI / 0x0D ORI / 0x0E XORI: zero-extend(imm16).
  - 0x0F LUI: {imm16, 16'b0}, then sign/zero per PC_W (upper bits 0 when PC_W>32).
  - Otherwise: sign-extend(imm16).
  - Extension is to PC_W; bits shifted past PC_W are dropped.
- out_jtarget is computed for every opcode; the consumer qualifies it with op 0x02/0x03.
- out_jump is the stored in_jump of the head entry. It is never delayed relative to its instruction.

Test Plan:
- Reset, then release; push pc=0xBFC00000 instr=0x1000FFFF (BEQ, imm=-1) with out_ready=1 -> next cycle out_valid=1, out_op=0x04, out_imm=0xFFFFFFFC, out_rs=0, count=1; following cycle out_valid=0, all data outputs 0.
- DEPTH=2, out_ready=0, three back-to-back pushes (ORI 0x3421F000, LUI 0x3C011234, J 0x08000010 at pc 0x80000008) -> count 1, 2, 2; in_ready=0 after second push; third not accepted; head out_imm=0x0000F000. Raise out_ready -> next head out_imm=0x12340000; in_ready=1 one cycle after pop.
- Simultaneous push/pop with count=1 -> count stays 1, outputs advance to the newly pushed entry, in order. Run 10 entries through DEPTH=3 to cover pointer wrap: FIFO order preserved.
- Fill to 2, then assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, pushed word absent. Then push one entry -> count=1.
- Push J at pc=0x80000008 with in_jump=1 -> out_jtarget=0x80000040 and out_jump=1 in the same cycle as out_instr.
- Assert reset=0 for one edge while count=2 with in_valid=1 -> count=0, out_valid=0, in_ready=1. Deassert reset -> normal pushes resume.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO between fetch and execute.
// It fully decodes the head entry.
//   fetch side  : in_valid/in_ready handshake; in_pc, in_instr, in_jump
//   execute side: out_valid/out_ready handshake; out_pc, out_instr, out_jump
//                 plus the decoded fields out_op, out_func, out_rs, out_rt,
//                 out_rd, out_shamt, out_imm and out_jtarget
//   flush       : drops every entry, including a push in the same cycle
//   count       : current occupancy
// Data outputs are decoded combinationally from registered state only.
// They are forced to zero while the queue is empty.
module decode_queue #(
  parameter int DEPTH    = 2,
  parameter int PC_W     = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       in_jump,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_jump,
  output logic [5:0]                 out_op,
  output logic [5:0]                 out_func,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [PC_W-1:0]            out_imm,
  output logic [PC_W-1:0]            out_jtarget,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            jump;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             push, pop;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // in_ready depends on occupancy only, so a full queue never accepts a push
  // even when it pops in the same cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset. Stale slots are never visible because the
  // pointers and the count are reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: in_pc, instr: in_instr, jump: in_jump};
  end

  entry_t             hd;
  logic signed [15:0] simm;
  logic [PC_W-1:0]    imm_x;

  assign hd   = mem[head];
  assign simm = hd.instr[15:0];

  // Size casts of a signed value sign-extend. Size casts of an unsigned value
  // zero-extend. Both truncate when PC_W is narrower than the source.
  always_comb begin
    imm_x = PC_W'(simm);
    case (hd.instr[31:26])
      6'h04, 6'h05:        imm_x = PC_W'(simm) << BR_SHIFT;
      6'h0C, 6'h0D, 6'h0E: imm_x = PC_W'(hd.instr[15:0]);
      6'h0F:               imm_x = PC_W'({hd.instr[15:0], 16'h0000});
      default:             imm_x = PC_W'(simm);
    endcase
  end

  assign out_pc      = out_valid ? hd.pc : '0;
  assign out_instr   = out_valid ? hd.instr : '0;
  assign out_jump    = out_valid & hd.jump;
  assign out_op      = out_valid ? hd.instr[31:26] : '0;
  assign out_func    = out_valid ? hd.instr[5:0] : '0;
  assign out_rs      = out_valid ? hd.instr[25:21] : '0;
  assign out_rt      = out_valid ? hd.instr[20:16] : '0;
  assign out_rd      = out_valid ? hd.instr[15:11] : '0;
  assign out_shamt   = out_valid ? hd.instr[10:6] : '0;
  assign out_imm     = out_valid ? imm_x : '0;
  assign out_jtarget = out_valid ?
                       PC_W'({hd.pc[PC_W-1:PC_W-4], hd.instr[25:0], 2'b00}) : '0;
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        jump;
    logic [31:0] imm;
    logic [31:0] jt;
  } vec_t;

  vec_t vec [10];
  int   q2 [$];
  int   q3 [$];
  int   tests = 0;
  int   failed = 0;

  logic clk = 0, reset = 0, flush = 0;
  always #5 clk = ~clk;

  logic        v2 = 0, r2 = 0, j2 = 0, v3 = 0, r3 = 0, j3 = 0;
  logic [31:0] pc2 = 0, in2 = 0, pc3 = 0, in3 = 0;
  logic        ir2, ov2, oj2, ir3, ov3, oj3;
  logic [31:0] opc2, oin2, im2, jt2, opc3, oin3, im3, jt3;
  logic [5:0]  op2, fn2, op3, fn3;
  logic [4:0]  rs2, rt2, rd2, sh2, rs3, rt3, rd3, sh3;
  logic [1:0]  cnt2, cnt3;

  decode_queue #(.DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(ir2), .in_pc(pc2),
    .in_instr(in2), .in_jump(j2), .flush(flush), .out_valid(ov2),
    .out_ready(r2), .out_pc(opc2), .out_instr(oin2), .out_jump(oj2),
    .out_op(op2), .out_func(fn2), .out_rs(rs2), .out_rt(rt2), .out_rd(rd2),
    .out_shamt(sh2), .out_imm(im2), .out_jtarget(jt2), .count(cnt2));

  decode_queue #(.DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_ready(ir3), .in_pc(pc3),
    .in_instr(in3), .in_jump(j3), .flush(flush), .out_valid(ov3),
    .out_ready(r3), .out_pc(opc3), .out_instr(oin3), .out_jump(oj3),
    .out_op(op3), .out_func(fn3), .out_rs(rs3), .out_rt(rt3), .out_rd(rd3),
    .out_shamt(sh3), .out_imm(im3), .out_jtarget(jt3), .count(cnt3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare one DUT against the scoreboard head (head < 0 means empty).
  task automatic cmp(input string t, input int head, input int size, input int depth,
                     input logic ir, input logic ov, input logic [1:0] cnt,
                     input logic [31:0] pc, input logic [31:0] ins, input logic j,
                     input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [4:0] sh, input logic [31:0] im, input logic [31:0] jt);
    vec_t e;
    e = '{pc: 0, instr: 0, jump: 0, imm: 0, jt: 0};
    if (head >= 0) e = vec[head];
    chk({t, ".in_ready"}, ir, size != depth);
    chk({t, ".out_valid"}, ov, size != 0);
    chk({t, ".count"}, cnt, size);
    chk({t, ".out_pc"}, pc, e.pc);
    chk({t, ".out_instr"}, ins, e.instr);
    chk({t, ".out_jump"}, j, e.jump);
    chk({t, ".out_op"}, op, e.instr[31:26]);
    chk({t, ".out_func"}, fn, e.instr[5:0]);
    chk({t, ".out_rs"}, rs, e.instr[25:21]);
    chk({t, ".out_rt"}, rt, e.instr[20:16]);
    chk({t, ".out_rd"}, rd, e.instr[15:11]);
    chk({t, ".out_shamt"}, sh, e.instr[10:6]);
    chk({t, ".out_imm"}, im, e.imm);
    chk({t, ".out_jtarget"}, jt, e.jt);
  endtask

  // One clock: drive at negedge, check both DUTs against the scoreboards,
  // update the scoreboards, and advance to the next negedge.
  task automatic step(input logic rst, input logic fl,
                      input logic v2_, input int i2, input logic r2_,
                      input logic v3_, input int i3, input logic r3_);
    int  h2, h3;
    logic p2, pp2, p3, pp3;
    reset = rst; flush = fl;
    v2 = v2_; pc2 = vec[i2].pc; in2 = vec[i2].instr; j2 = vec[i2].jump; r2 = r2_;
    v3 = v3_; pc3 = vec[i3].pc; in3 = vec[i3].instr; j3 = vec[i3].jump; r3 = r3_;
    h2 = (q2.size() != 0) ? q2[0] : -1;
    h3 = (q3.size() != 0) ? q3[0] : -1;
    cmp("d2", h2, q2.size(), 2, ir2, ov2, cnt2, opc2, oin2, oj2, op2, fn2,
        rs2, rt2, rd2, sh2, im2, jt2);
    cmp("d3", h3, q3.size(), 3, ir3, ov3, cnt3, opc3, oin3, oj3, op3, fn3,
        rs3, rt3, rd3, sh3, im3, jt3);
    if (!rst || fl) begin
      q2.delete(); q3.delete();
    end else begin
      p2 = v2_ && q2.size() < 2;  pp2 = r2_ && q2.size() > 0;
      p3 = v3_ && q3.size() < 3;  pp3 = r3_ && q3.size() > 0;
      if (pp2) void'(q2.pop_front());
      if (p2)  q2.push_back(i2);
      if (pp3) void'(q3.pop_front());
      if (p3)  q3.push_back(i3);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  n;
    logic v, r;
    vec[0] = '{32'hBFC00000, 32'h1000FFFF, 1'b0, 32'hFFFFFFFC, 32'hB003FFFC}; // BEQ -1
    vec[1] = '{32'h80000000, 32'h3421F000, 1'b0, 32'h0000F000, 32'h8087C000}; // ORI
    vec[2] = '{32'h80000004, 32'h3C011234, 1'b0, 32'h12340000, 32'h800448D0}; // LUI
    vec[3] = '{32'h80000008, 32'h08000010, 1'b1, 32'h00000010, 32'h80000040}; // J
    vec[4] = '{32'h00400000, 32'h1443FFF8, 1'b0, 32'hFFFFFFE0, 32'h010FFFE0}; // BNE -8
    vec[5] = '{32'h00400004, 32'h38428000, 1'b0, 32'h00008000, 32'h010A0000}; // XORI
    vec[6] = '{32'h00400008, 32'h20088000, 1'b0, 32'hFFFF8000, 32'h00220000}; // ADDI
    vec[7] = '{32'h9000000C, 32'h01095020, 1'b1, 32'h00005020, 32'h94254080}; // ADD
    vec[8] = '{32'hA0000000, 32'h30A5FFFF, 1'b0, 32'h0000FFFF, 32'hA297FFFC}; // ANDI
    vec[9] = '{32'h00000000, 32'h00084080, 1'b0, 32'h00004080, 32'h00210200}; // SLL

    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1, 1, 0);   // pushes under reset are ignored

    // BEQ push with out_ready=1: visible one cycle later, then gone.
    step(1, 0, 1, 0, 1, 0, 0, 0);
    chk("t1.imm", im2, 32'hFFFFFFFC);
    chk("t1.op", op2, 6'h04);
    chk("t1.count", cnt2, 2'd1);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    chk("t1.empty_imm", im2, 32'h0);

    // Backpressure on DEPTH=2: the third push is refused.
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 2, 0, 0, 0, 0);
    step(1, 0, 1, 3, 0, 0, 0, 0);
    chk("t2.in_ready_full", ir2, 1'b0);
    chk("t2.head_imm", im2, 32'h0000F000);
    step(1, 0, 0, 0, 1, 0, 0, 0);   // pop while full, in_ready still 0
    chk("t2.lui_imm", im2, 32'h12340000);
    chk("t2.in_ready_after_pop", ir2, 1'b1);
    step(1, 0, 1, 3, 1, 0, 0, 0);   // J with jump marker
    chk("t5.jtarget", jt2, 32'h80000040);
    chk("t5.jump", oj2, 1'b1);
    step(1, 0, 0, 0, 1, 0, 0, 0);

    // Table: stream every vector with simultaneous push/pop.
    for (int i = 0; i < 10; i++) step(1, 0, 1, i, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);

    // DEPTH=3: fill to full, then a mixed stream of 10 entries across the wrap.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, i, 0);
    chk("t3.d3_full_count", cnt3, 2'd3);
    chk("t3.d3_in_ready", ir3, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1);
    n = 0;
    for (int k = 0; k < 70; k++) begin
      v = (n < 10) && (k >= 40 || $urandom_range(0, 3) != 0);
      r = (k >= 40) || (k >= 4 && $urandom_range(0, 2) != 0);
      if (v && q3.size() < 3) begin
        step(1, 0, 0, 0, 0, v, n, r);
        n++;
      end else begin
        step(1, 0, 0, 0, 0, v, n, r);
      end
    end
    chk("t3.d3_all_pushed", n, 10);
    chk("t3.d3_drained", cnt3, 2'd0);

    // Flush with a concurrent push.
    step(1, 0, 1, 4, 0, 1, 4, 0);
    step(1, 0, 1, 5, 0, 1, 5, 0);
    step(1, 1, 1, 6, 0, 1, 6, 0);
    chk("t4.flush_count", cnt2, 2'd0);
    chk("t4.flush_valid", ov2, 1'b0);
    step(1, 0, 1, 7, 0, 0, 0, 0);
    chk("t4.after_flush_count", cnt2, 2'd1);
    chk("t4.after_flush_instr", oin2, 32'h01095020);

    // Reset mid-operation with in_valid=1.
    step(1, 0, 1, 8, 0, 0, 0, 0);
    step(0, 0, 1, 9, 0, 0, 0, 0);
    chk("t6.reset_count", cnt2, 2'd0);
    chk("t6.reset_in_ready", ir2, 1'b1);
    chk("t6.reset_valid", ov2, 1'b0);
    step(1, 0, 1, 2, 0, 0, 0, 0);
    chk("t6.resume_count", cnt2, 2'd1);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
